mock_mem_ctrl: RTL and testbench

- Parametrised behavioural memory model for CPU-level testbenches; the next generation of the single-cycle mock memory.
- Adds configurable address/data width, wait-state latency with a valid/ready request handshake, and a write-protected ROM region that reports errors.
- Adds a hardware clear sweep after reset and a testbench backdoor preload port.
- Sits on the CPU bus in place of the real MMU in unit and integration benches.

---
 rtl/mock_mem_pkg.sv | 23 ++
 rtl/mock_mem_ctrl_if.sv | 28 ++
 rtl/mock_mem_array.sv | 30 +++
 rtl/mock_mem_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mock_mem_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mock_mem_pkg.sv
// Shared definitions for the mock memory controller.
//   state_e  : controller FSM states.
//   WCNT_W   : width of the wait-state down-counter (WAIT_STATES 0..15).
//   in_rom() : inclusive address-range test for the write-protected region.
package mock_mem_pkg;

  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Operands are widened to 32 bits so one helper serves any ADDR_W.
  function automatic logic in_rom(input logic [31:0] addr,
                                  input logic [31:0] base,
                                  input logic [31:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/mock_mem_ctrl_if.sv
// Request/response bus of the mock memory.
//   master : CPU side, drives req_valid/req_we/req_addr/req_wdata.
//   slave  : memory side, drives req_ready/rsp_valid/rsp_rdata/rsp_err.
interface mock_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mock_mem_array.sv
// Word storage for the mock memory: 2**ADDR_W words of DATA_W bits.
//   clk      : clock.
//   we_i     : write strobe for the single synchronous write port.
//   waddr_i  : write address.
//   wdata_i  : write data.
//   raddr_i  : asynchronous read address.
//   rdata_o  : read data (contents before the current edge's write).
module mock_mem_array #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // NOTE: the storage has no reset; the controller's clear sweep initialises
  // it, and a reset branch here would prevent mapping to a RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mock_mem_ctrl.sv
// Behavioural memory model for CPU-level benches.
//   clk, reset   : clock; asynchronous active-high reset.
//   bus          : request (valid/ready, we, addr, wdata) and one-cycle
//                  response (valid, rdata, err) channel.
//   init_busy    : high while the post-reset clear sweep runs.
//   preload_*    : backdoor write, ignored during the sweep, bypasses ROM.
// A request accepted in IDLE is answered WAIT_STATES cycles later; writes
// into [ROM_BASE, ROM_LIMIT] are dropped and flagged when ROM_EN is set.
module mock_mem_ctrl
  import mock_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       WAIT_STATES = 2,
  parameter logic [DATA_W-1:0] FILL        = '0,
  parameter bit                ROM_EN      = 1'b1,
  parameter int unsigned       ROM_BASE    = 32'h0000,
  parameter int unsigned       ROM_LIMIT   = 32'h7FFF
) (
  input  logic              clk,
  input  logic              reset,
  mock_mem_ctrl_if.slave    bus,
  output logic              init_busy,
  input  logic              preload_en,
  input  logic [ADDR_W-1:0] preload_addr,
  input  logic [DATA_W-1:0] preload_data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  // Operands of the response being formed on this edge.
  logic              go_resp;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              commit;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // With zero wait states the response forms on the accept edge itself, so
  // the live request feeds it; otherwise the captured copy does. Kept apart
  // from the next-state logic so the array read path forms no loop.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    go_resp  = 1'b0;
    op_we    = we_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (state_q == IDLE && bus.req_valid && WAIT_STATES == 0) begin
      go_resp  = 1'b1;
      op_we    = bus.req_we;
      op_addr  = bus.req_addr;
      op_wdata = bus.req_wdata;
    end else if (state_q == WAIT && wait_cnt_q == '0) begin
      go_resp = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    wait_cnt_d  = wait_cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit      = 1'b0;

    unique case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_STATES != 0) begin
            state_d    = WAIT;
            wait_cnt_d = WCNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - 1'b1;
      end
      RESP: state_d = IDLE;
      default: state_d = CLEAR;
    endcase

    if (go_resp) begin
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      if (!op_we) begin
        rsp_rdata_d = mem_rdata;
      end else if (ROM_EN && in_rom(32'(op_addr), ROM_BASE, ROM_LIMIT)) begin
        rsp_err_d = 1'b1;
      end else begin
        commit = 1'b1;
      end
    end
  end

  // Single write port: sweep, then bus commit, then preload. A bus commit
  // therefore wins a same-edge collision with the backdoor.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = preload_addr;
    mem_wdata = preload_data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = FILL;
    end else if (commit) begin
      mem_we    = 1'b1;
      mem_waddr = op_addr;
      mem_wdata = op_wdata;
    end else if (preload_en) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: registers are updated with <= so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      wait_cnt_q  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  mock_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (op_addr),
    .rdata_o (mem_rdata)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign init_busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_mock_mem_ctrl.sv
// Directed bench for mock_mem_ctrl. Two small instances share the clock:
//   dut_a : ADDR_W=8, WAIT_STATES=2, FILL=A5, ROM 0x00..0x7F
//   dut_b : ADDR_W=8, WAIT_STATES=0, FILL=00, ROM 0x00..0x7F
// 16-bit addresses of the original scenarios map to their upper byte
// (0x9000 -> 0x90, 0x0100 -> 0x01, 0xA000 -> 0xA0).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mock_mem_ctrl;

  logic       clk;
  logic       reset_a, reset_b;
  logic       busy_a, busy_b;
  logic       pl_en_a, pl_en_b;
  logic [7:0] pl_addr_a, pl_addr_b;
  logic [7:0] pl_data_a, pl_data_b;

  int checks = 0;
  int errors = 0;

  mock_mem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) ifa ();
  mock_mem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) ifb ();

  mock_mem_ctrl #(
    .ADDR_W(8), .DATA_W(8), .WAIT_STATES(2), .FILL(8'hA5),
    .ROM_EN(1'b1), .ROM_BASE(32'h00), .ROM_LIMIT(32'h7F)
  ) dut_a (
    .clk(clk), .reset(reset_a), .bus(ifa.slave), .init_busy(busy_a),
    .preload_en(pl_en_a), .preload_addr(pl_addr_a), .preload_data(pl_data_a)
  );

  mock_mem_ctrl #(
    .ADDR_W(8), .DATA_W(8), .WAIT_STATES(0), .FILL(8'h00),
    .ROM_EN(1'b1), .ROM_BASE(32'h00), .ROM_LIMIT(32'h7F)
  ) dut_b (
    .clk(clk), .reset(reset_b), .bus(ifb.slave), .init_busy(busy_b),
    .preload_en(pl_en_b), .preload_addr(pl_addr_b), .preload_data(pl_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on dut_a; lat = cycles from the accept edge until rsp_valid
  // is seen (-1 if it never arrives).
  task automatic a_xact(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output logic err, output int lat);
    lat = -1; rd = '0; err = 1'b0;
    ifa.req_valid = 1'b1; ifa.req_we = we; ifa.req_addr = addr; ifa.req_wdata = wd;
    for (int i = 0; i < 40 && !ifa.req_ready; i++) tick();
    if (ifa.req_ready) begin
      tick();
      ifa.req_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (ifa.rsp_valid) begin lat = i; rd = ifa.rsp_rdata; err = ifa.rsp_err; break; end
        tick();
      end
    end
    ifa.req_valid = 1'b0;
  endtask

  task automatic b_xact(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output logic err, output int lat);
    lat = -1; rd = '0; err = 1'b0;
    ifb.req_valid = 1'b1; ifb.req_we = we; ifb.req_addr = addr; ifb.req_wdata = wd;
    for (int i = 0; i < 40 && !ifb.req_ready; i++) tick();
    if (ifb.req_ready) begin
      tick();
      ifb.req_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (ifb.rsp_valid) begin lat = i; rd = ifb.rsp_rdata; err = ifb.rsp_err; break; end
        tick();
      end
    end
    ifb.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] addrs [3] = '{8'h00, 8'h7F, 8'hFF};
    logic [7:0] rd;
    logic       err;
    int         lat;
    int         n;
    reset_a = 1'b1; reset_b = 1'b1;
    tick(); tick();
    checks++;
    if (busy_a !== 1'b1 || ifa.req_ready !== 1'b0 || ifa.rsp_valid !== 1'b0 ||
        ifa.rsp_rdata !== 8'h00 || ifa.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b ready=%b valid=%b rdata=%h err=%b, want 1 0 0 00 0",
               busy_a, ifa.req_ready, ifa.rsp_valid, ifa.rsp_rdata, ifa.rsp_err);
    end
    reset_a = 1'b0; reset_b = 1'b0;
    // Backdoor writes held through dut_b's whole sweep must all be dropped.
    pl_en_b = 1'b1; pl_addr_b = 8'hB0; pl_data_b = 8'h77;
    n = 0;
    while (busy_a && n < 1000) begin tick(); n++; end
    pl_en_b = 1'b0;
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL sweep_length: busy cycles=%0d, want 256", n);
    end
    checks++;
    if (busy_b !== 1'b0 || ifa.req_ready !== 1'b1 || ifb.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_sweep: busy_b=%b ready_a=%b ready_b=%b, want 0 1 1",
               busy_b, ifa.req_ready, ifb.req_ready);
    end
    foreach (addrs[i]) begin
      a_xact(1'b0, addrs[i], 8'h00, rd, err, lat);
      checks++;
      if (rd !== 8'hA5 || err !== 1'b0 || lat != 2) begin
        errors++;
        $display("FAIL fill_read_%h: rdata=%h err=%b lat=%0d, want A5 0 2", addrs[i], rd, err, lat);
      end
    end
  endtask

  task automatic test_wait_write();
    logic [4:0] rdy_pat, vld_pat;
    logic       err_at_rsp;
    logic [7:0] rd;
    logic       err;
    int         lat;
    ifa.req_valid = 1'b1; ifa.req_we = 1'b1; ifa.req_addr = 8'h90; ifa.req_wdata = 8'h3C;
    for (int i = 0; i < 40 && !ifa.req_ready; i++) tick();
    tick();                       // edge E0
    ifa.req_valid = 1'b0;
    err_at_rsp = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      rdy_pat[k] = ifa.req_ready;
      vld_pat[k] = ifa.rsp_valid;
      if (k == 2) err_at_rsp = ifa.rsp_err;
    end
    checks++;
    if (rdy_pat !== 5'b11000) begin
      errors++;
      $display("FAIL ready_gap: pattern=%b, want 11000", rdy_pat);
    end
    checks++;
    if (vld_pat !== 5'b00100 || err_at_rsp !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp_pulse: valid=%b err=%b, want 00100 0", vld_pat, err_at_rsp);
    end
    a_xact(1'b0, 8'h90, 8'h00, rd, err, lat);
    checks++;
    if (rd !== 8'h3C || err !== 1'b0) begin
      errors++;
      $display("FAIL write_readback: rdata=%h err=%b, want 3C 0", rd, err);
    end
  endtask

  task automatic test_rom();
    logic [7:0] rd;
    logic       err;
    int         lat;
    pl_en_a = 1'b1; pl_addr_a = 8'h01; pl_data_a = 8'h42;
    tick();
    pl_en_a = 1'b0;
    a_xact(1'b1, 8'h01, 8'hFF, rd, err, lat);
    checks++;
    if (err !== 1'b1 || rd !== 8'h00) begin
      errors++;
      $display("FAIL rom_write_err: err=%b rdata=%h, want 1 00", err, rd);
    end
    a_xact(1'b0, 8'h01, 8'h00, rd, err, lat);
    checks++;
    if (rd !== 8'h42 || err !== 1'b0) begin
      errors++;
      $display("FAIL rom_preserved: rdata=%h err=%b, want 42 0", rd, err);
    end
    a_xact(1'b1, 8'h7F, 8'h11, rd, err, lat);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL rom_limit_err: err=%b, want 1", err);
    end
    a_xact(1'b1, 8'h80, 8'h5A, rd, err, lat);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL above_limit_err: err=%b, want 0", err);
    end
    a_xact(1'b0, 8'h80, 8'h00, rd, err, lat);
    checks++;
    if (rd !== 8'h5A) begin
      errors++;
      $display("FAIL above_limit_read: rdata=%h, want 5A", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [4] = '{8'hC0, 8'hC3, 8'hC6, 8'hC9};
    logic       acc;
    int         idx;
    int         last;
    for (int i = 0; i < 4; i++) begin
      pl_en_b = 1'b1; pl_addr_b = 8'h10 + 8'(i); pl_data_b = exp_d[i];
      tick();
    end
    pl_en_b = 1'b0;
    for (int i = 0; i < 40 && !ifb.req_ready; i++) tick();
    idx = 0; last = -1;
    ifb.req_valid = 1'b1; ifb.req_we = 1'b0; ifb.req_addr = 8'h10;
    for (int c = 0; c < 16 && idx < 4; c++) begin
      acc = ifb.req_ready;
      tick();
      checks++;
      if (ifb.rsp_valid !== acc) begin
        errors++;
        $display("FAIL b2b_valid_c%0d: rsp_valid=%b, want %b", c, ifb.rsp_valid, acc);
      end
      if (acc) begin
        checks++;
        if (ifb.rsp_rdata !== exp_d[idx] || (last >= 0 && c - last != 2)) begin
          errors++;
          $display("FAIL b2b_read_%0d: rdata=%h gap=%0d, want %h 2",
                   idx, ifb.rsp_rdata, c - last, exp_d[idx]);
        end
        last = c;
        idx++;
        ifb.req_addr = 8'h10 + 8'(idx);
      end
    end
    ifb.req_valid = 1'b0;
    checks++;
    if (idx != 4) begin
      errors++;
      $display("FAIL b2b_count: accepts=%0d, want 4", idx);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] rd;
    logic       err;
    int         lat;
    int         n;
    logic       saw_rsp;
    for (int i = 0; i < 40 && !ifa.req_ready; i++) tick();
    ifa.req_valid = 1'b1; ifa.req_we = 1'b1; ifa.req_addr = 8'h91; ifa.req_wdata = 8'h66;
    tick();                       // accept
    ifa.req_valid = 1'b0;
    tick();                       // still in WAIT, response due on next edge
    reset_a = 1'b1;
    #1;
    saw_rsp = ifa.rsp_valid;
    tick(); tick();
    saw_rsp |= ifa.rsp_valid;
    reset_a = 1'b0;
    n = 0;
    while (busy_a && n < 1000) begin tick(); n++; saw_rsp |= ifa.rsp_valid; end
    tick(); tick();
    saw_rsp |= ifa.rsp_valid;
    checks++;
    if (n != 256 || saw_rsp !== 1'b0) begin
      errors++;
      $display("FAIL abort_sweep: busy cycles=%0d saw_rsp=%b, want 256 0", n, saw_rsp);
    end
    a_xact(1'b0, 8'h91, 8'h00, rd, err, lat);
    checks++;
    if (rd !== 8'hA5) begin
      errors++;
      $display("FAIL abort_no_commit: rdata=%h, want A5", rd);
    end
    a_xact(1'b0, 8'h90, 8'h00, rd, err, lat);
    checks++;
    if (rd !== 8'hA5) begin
      errors++;
      $display("FAIL abort_resweep: rdata=%h, want A5", rd);
    end
  endtask

  task automatic test_collision();
    logic [7:0] rd;
    logic       err;
    int         lat;
    for (int i = 0; i < 40 && !ifb.req_ready; i++) tick();
    pl_en_b = 1'b1; pl_addr_b = 8'hA0; pl_data_b = 8'h11;
    ifb.req_valid = 1'b1; ifb.req_we = 1'b1; ifb.req_addr = 8'hA0; ifb.req_wdata = 8'h22;
    tick();
    pl_en_b = 1'b0; ifb.req_valid = 1'b0;
    checks++;
    if (ifb.rsp_valid !== 1'b1 || ifb.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL collide_rsp: valid=%b err=%b, want 1 0", ifb.rsp_valid, ifb.rsp_err);
    end
    b_xact(1'b0, 8'hA0, 8'h00, rd, err, lat);
    checks++;
    if (rd !== 8'h22 || lat != 0) begin
      errors++;
      $display("FAIL collide_read: rdata=%h lat=%0d, want 22 0", rd, lat);
    end
    b_xact(1'b0, 8'hB0, 8'h00, rd, err, lat);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL preload_in_clear: rdata=%h, want 00", rd);
    end
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    pl_en_a = 1'b0; pl_addr_a = '0; pl_data_a = '0;
    pl_en_b = 1'b0; pl_addr_b = '0; pl_data_b = '0;
    ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
    test_reset();
    test_wait_write();
    test_rom();
    test_back_to_back();
    test_reset_abort();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
